// File: rtl/gpool_pkg.sv
// Shared types and constant helpers for the global pooling stage.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package gpool_pkg;

    typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} gpool_state_t;
    typedef enum logic {POOL_AVG = 1'b0, POOL_MAX = 1'b1} pool_mode_t;

    // floor(2^rshift / hw + 0.5), computed as floor((2^(rshift+1) + hw) / (2*hw))
    function automatic longint recip(input int hw, input int rshift);
        return ((longint'(1) <<< (rshift + 1)) + longint'(hw)) / (longint'(2) * longint'(hw));
    endfunction

    // Clamp x to the signed w-bit range
    function automatic longint sat_signed(input longint x, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - longint'(1);
        lo = -(longint'(1) <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/gpool_lane.sv
// One channel lane: per-group accumulator with load/sum/max update and a normalize read path.
// Latency: accumulator updates on the accepting edge; read path is combinational.
// Backpressure: none here; the parent only writes on accepted beats.
module gpool_lane
    import gpool_pkg::*;
#(
    parameter int     DATA_WIDTH = 16,
    parameter int     ACC_WIDTH  = 23,
    parameter int     G          = 20,
    parameter int     GW         = 5,
    parameter int     RSHIFT     = 20,
    parameter longint RECIP      = 21400
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic                         i_first,
    input  pool_mode_t                   i_mode,
    input  logic [GW-1:0]                i_wr_grp,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    input  logic [GW-1:0]                i_rd_grp,
    output logic signed [DATA_WIDTH-1:0] o_res
);

    localparam int PW = ACC_WIDTH + RSHIFT + 1;
    localparam logic signed [PW-1:0] RECIP_P = PW'(RECIP);
    localparam logic signed [PW-1:0] HALF_P  = PW'(longint'(1) <<< (RSHIFT - 1));

    logic signed [ACC_WIDTH-1:0] r_acc [G];
    logic signed [ACC_WIDTH-1:0] w_ext;
    logic signed [ACC_WIDTH-1:0] w_cur;
    logic signed [ACC_WIDTH-1:0] w_rd;
    logic signed [PW-1:0]        w_prod;
    logic signed [PW-1:0]        w_shr;

    assign w_ext  = {{(ACC_WIDTH - DATA_WIDTH){i_sample[DATA_WIDTH-1]}}, i_sample};
    assign w_cur  = r_acc[i_wr_grp];
    assign w_rd   = r_acc[i_rd_grp];
    assign w_prod = PW'(w_rd) * RECIP_P + HALF_P;
    assign w_shr  = w_prod >>> RSHIFT;

    // Pixel 0 loads the sample (no clear cycle); later pixels sum or keep the signed max
    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_first) begin
                r_acc[i_wr_grp] <= w_ext;
            end else if (i_mode == POOL_MAX) begin
                if (w_ext > w_cur) begin
                    r_acc[i_wr_grp] <= w_ext;
                end
            end else begin
                r_acc[i_wr_grp] <= w_cur + w_ext;
            end
        end
    end

    // Max result is already in sample range; average is scaled by the reciprocal and clamped
    always_comb begin
        o_res = '0;
        if (i_mode == POOL_MAX) begin
            o_res = w_rd[DATA_WIDTH-1:0];
        end else begin
            o_res = DATA_WIDTH'(sat_signed(longint'(w_shr), DATA_WIDTH));
        end
    end

endmodule

// File: rtl/global_avg_pool_stream.sv
// Streaming global avg/max pooling of a CHANNELS x HEIGHT x WIDTH map, LANES channels per beat.
// Latency: first result beat valid 1 cycle after the final input accept, then 1 beat/cycle.
// Backpressure: in_ready low for the whole drain; result beats hold while out_ready is low.
module global_avg_pool_stream
    import gpool_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  CHANNELS   = 160,
    parameter int  HEIGHT     = 7,
    parameter int  WIDTH      = 7,
    parameter int  LANES      = 8,
    parameter int  RSHIFT     = 20,
    parameter int  ACC_WIDTH  = DATA_WIDTH + $clog2(HEIGHT * WIDTH) + 1,
    localparam int G          = CHANNELS / LANES,
    localparam int GRP_W      = (G > 1) ? $clog2(G) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [GRP_W-1:0]              out_group,
    output logic                          out_last,
    output logic                          frame_err
);

    localparam int     HW    = HEIGHT * WIDTH;
    localparam int     PIX_W = (HW > 1) ? $clog2(HW) : 1;
    localparam longint RECIP = recip(HW, RSHIFT);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(HW - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(G - 1);

    if (CHANNELS % LANES != 0) begin : g_cfg_check
        $error("CHANNELS must be a multiple of LANES");
    end

    gpool_state_t               r_state;
    gpool_state_t               w_state_nxt;
    logic [PIX_W-1:0]           r_pix;
    logic [GRP_W-1:0]           r_grp;
    pool_mode_t                 r_mode_q;
    logic                       r_frame_err;
    logic                       r_out_vld;
    logic [LANES*DATA_WIDTH-1:0] r_out_dat;
    logic [GRP_W-1:0]           r_out_grp;
    logic                       r_out_last;

    logic                       w_in_rdy;
    logic                       w_in_acc;
    logic                       w_final;
    logic                       w_first;
    logic                       w_out_hs;
    logic                       w_load;
    logic [GRP_W-1:0]           w_rd_grp;
    logic [LANES*DATA_WIDTH-1:0] w_lane_res;

    assign w_final  = (r_pix == PIX_LAST) && (r_grp == GRP_LAST);
    assign w_first  = (r_pix == '0);
    assign w_in_acc = in_valid && w_in_rdy;
    assign w_out_hs = r_out_vld && out_ready;
    // Group 0 is read in the bubble cycle after the last accept, then the successor of each sent beat
    assign w_rd_grp = r_out_vld ? (r_out_grp + GRP_W'(1)) : '0;

    // Next-state and drain-load decode
    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ACCUM: begin
                w_in_rdy = 1'b1;
                if (in_valid && w_final) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_load = !r_out_vld || (out_ready && !r_out_last);
                if (w_out_hs && r_out_last) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat counters, mode latch on the first beat, sticky framing check against the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix       <= '0;
            r_grp       <= '0;
            r_mode_q    <= POOL_AVG;
            r_frame_err <= 1'b0;
        end else if (w_in_acc) begin
            if (w_first && (r_grp == '0)) begin
                r_mode_q <= pool_mode_t'(mode);
            end
            if (in_last != w_final) begin
                r_frame_err <= 1'b1;
            end
            if (r_grp == GRP_LAST) begin
                r_grp <= '0;
                r_pix <= w_final ? '0 : (r_pix + PIX_W'(1));
            end else begin
                r_grp <= r_grp + GRP_W'(1);
            end
        end
    end

    // Output register: load next group on each handshake, drop valid after the last group
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_grp  <= '0;
            r_out_last <= 1'b0;
        end else if (w_load) begin
            r_out_vld  <= 1'b1;
            r_out_dat  <= w_lane_res;
            r_out_grp  <= w_rd_grp;
            r_out_last <= (w_rd_grp == GRP_LAST);
        end else if (w_out_hs) begin
            r_out_vld  <= 1'b0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gpool_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .G          (G),
            .GW         (GRP_W),
            .RSHIFT     (RSHIFT),
            .RECIP      (RECIP)
        ) u_lane (
            .clk      (clk),
            .i_we     (w_in_acc),
            .i_first  (w_first),
            .i_mode   (r_mode_q),
            .i_wr_grp (r_grp),
            .i_sample (in_data[l*DATA_WIDTH +: DATA_WIDTH]),
            .i_rd_grp (w_rd_grp),
            .o_res    (w_lane_res[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign in_ready  = w_in_rdy;
    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign out_group = r_out_grp;
    assign out_last  = r_out_last;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_global_avg_pool_stream.sv
// Directed bench: small 4ch/2-lane/2x2 instance for function, default instance for frame timing.
// Latency: n/a.
// Backpressure: exercised via out_ready stalls on the small instance.
module tb_global_avg_pool_stream;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            mode;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_data;
    logic [0:0]      out_group;
    logic            out_last;
    logic            frame_err;

    logic            b_in_valid;
    logic            b_in_ready;
    logic [8*DW-1:0] b_in_data;
    logic            b_in_last;
    logic            b_out_valid;
    logic            b_out_ready;
    logic [8*DW-1:0] b_out_data;
    logic [4:0]      b_out_group;
    logic            b_out_last;
    logic            b_frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_ferr = 1'b0;
    logic signed [DW-1:0] fd [4][4];  // [pixel][channel]

    global_avg_pool_stream #(
        .DATA_WIDTH (16),
        .CHANNELS   (4),
        .HEIGHT     (2),
        .WIDTH      (2),
        .LANES      (2),
        .RSHIFT     (20)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_group (out_group),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    global_avg_pool_stream u_big (
        .clk       (clk),
        .rst       (rst),
        .mode      (1'b0),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_group (b_out_group),
        .out_last  (b_out_last),
        .frame_err (b_frame_err)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint s16(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic clear_fd();
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) begin
                fd[p][c] = '0;
            end
        end
    endtask

    task automatic set_ch(input int ch, input int a, input int b, input int c, input int d);
        fd[0][ch] = DW'(a);
        fd[1][ch] = DW'(b);
        fd[2][ch] = DW'(c);
        fd[3][ch] = DW'(d);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Beats in pixel-major/group-minor order; mode flips after beat 0, one idle cycle after beat 3
    task automatic send_frame(input logic mode0, input int err_beat, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            int pix;
            int g;
            pix      = k / 2;
            g        = k % 2;
            in_data  = {fd[pix][g*2+1], fd[pix][g*2]};
            in_last  = (k == 7) || (k == err_beat);
            mode     = (k == 0) ? mode0 : ~mode0;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (err_beat >= 0) begin
                check_val("frame_err_track", longint'(frame_err), (k >= err_beat) ? 1 : 0);
            end
            if (k == 3) begin
                in_last = 1'b1;
                in_data = '1;
                @(posedge clk); #1;
                in_last = 1'b0;
            end
        end
    endtask

    // Called right after the final beat with out_ready=1; checks exact drain timing
    task automatic drain_check(input longint e0, input longint e1, input longint e2, input longint e3);
        check_val("bubble_out_valid", longint'(out_valid), 0);
        check_val("bubble_in_ready", longint'(in_ready), 0);
        @(posedge clk); #1;
        check_val("g0_valid", longint'(out_valid), 1);
        check_val("g0_group", longint'(out_group), 0);
        check_val("g0_last", longint'(out_last), 0);
        check_val("g0_lane0", s16(out_data[15:0]), e0);
        check_val("g0_lane1", s16(out_data[31:16]), e1);
        @(posedge clk); #1;
        check_val("g1_valid", longint'(out_valid), 1);
        check_val("g1_group", longint'(out_group), 1);
        check_val("g1_last", longint'(out_last), 1);
        check_val("g1_lane0", s16(out_data[15:0]), e2);
        check_val("g1_lane1", s16(out_data[31:16]), e3);
        @(posedge clk); #1;
        check_val("post_out_valid", longint'(out_valid), 0);
        check_val("post_in_ready", longint'(in_ready), 1);
        check_val("post_frame_err", longint'(frame_err), longint'(exp_ferr));
    endtask

    initial begin
        int nb;
        rst         = 1'b1;
        mode        = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_last   = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        clear_fd();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", longint'(in_ready), 1);
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_out_data", longint'(out_data), 0);
        check_val("rst_out_group", longint'(out_group), 0);
        check_val("rst_out_last", longint'(out_last), 0);
        check_val("rst_frame_err", longint'(frame_err), 0);
        rst = 1'b0;

        // average: ch0 4,8,12,16 -> 10
        clear_fd();
        set_ch(0, 4, 8, 12, 16);
        send_frame(1'b0, -1, 8);
        drain_check(10, 0, 0, 0);

        // rounding: -7/4 -> -2, 7/4 -> 2
        clear_fd();
        set_ch(1, -1, -2, -2, -2);
        set_ch(3, 1, 2, 2, 2);
        send_frame(1'b0, -1, 8);
        drain_check(0, -2, 0, 2);

        // max mode latched on beat 0
        clear_fd();
        set_ch(0, 1, 1, 1, 1);
        set_ch(1, -3, -9, -4, -8);
        set_ch(2, -5, 3, -7, 2);
        send_frame(1'b1, -1, 8);
        drain_check(1, -3, 3, 0);

        // backpressure on the max frame
        out_ready = 1'b0;
        send_frame(1'b1, -1, 8);
        @(posedge clk); #1;
        check_val("bp_first_valid", longint'(out_valid), 1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_val("bp_hold_valid", longint'(out_valid), 1);
            check_val("bp_hold_group", longint'(out_group), 0);
            check_val("bp_hold_lane0", s16(out_data[15:0]), 1);
            check_val("bp_hold_lane1", s16(out_data[31:16]), -3);
            check_val("bp_hold_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_g1_valid", longint'(out_valid), 1);
        check_val("bp_g1_group", longint'(out_group), 1);
        check_val("bp_g1_last", longint'(out_last), 1);
        check_val("bp_g1_lane0", s16(out_data[15:0]), 3);
        @(posedge clk); #1;
        check_val("bp_end_valid", longint'(out_valid), 0);
        check_val("bp_end_in_ready", longint'(in_ready), 1);

        // framing: early in_last on beat 3 of 8
        clear_fd();
        set_ch(1, -1, -2, -2, -2);
        set_ch(3, 1, 2, 2, 2);
        exp_ferr = 1'b1;
        send_frame(1'b0, 2, 8);
        drain_check(0, -2, 0, 2);
        repeat (2) @(posedge clk);
        #1;
        check_val("ferr_sticky", longint'(frame_err), 1);
        pulse_rst();
        exp_ferr = 1'b0;
        check_val("ferr_cleared", longint'(frame_err), 0);

        // reset mid-frame after 5 garbage beats, then a clean frame
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) begin
                fd[p][c] = DW'(1000 + 100 * p + c);
            end
        end
        send_frame(1'b1, -1, 5);
        pulse_rst();
        check_val("midrst_in_ready", longint'(in_ready), 1);
        clear_fd();
        set_ch(0, 4, 8, 12, 16);
        send_frame(1'b0, -1, 8);
        drain_check(10, 0, 0, 0);

        // default instance: 980 beats of 100, first result 1 cycle after the last accept
        b_in_data = {8{16'd100}};
        for (int k = 0; k < 980; k++) begin
            b_in_valid = 1'b1;
            b_in_last  = (k == 979);
            @(posedge clk); #1;
            if (k == 978) begin
                check_val("big_pre_valid", longint'(b_out_valid), 0);
                check_val("big_pre_in_ready", longint'(b_in_ready), 1);
            end
        end
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        check_val("big_bubble_valid", longint'(b_out_valid), 0);
        @(posedge clk); #1;
        check_val("big_first_valid", longint'(b_out_valid), 1);
        check_val("big_first_group", longint'(b_out_group), 0);
        check_val("big_lane0", s16(b_out_data[15:0]), 100);
        check_val("big_lane7", s16(b_out_data[127:112]), 100);
        nb = 1;
        for (int c = 0; c < 30 && !(b_out_valid && b_out_last); c++) begin
            @(posedge clk); #1;
            if (b_out_valid) begin
                nb++;
            end
        end
        check_val("big_beats", longint'(nb), 20);
        check_val("big_last_group", longint'(b_out_group), 19);
        check_val("big_last_flag", longint'(b_out_last), 1);
        check_val("big_frame_err", longint'(b_frame_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/global_avg_pool_stream.md
# global_avg_pool_stream

Streaming global pooling stage that reduces a CHANNELS×HEIGHT×WIDTH feature map to one value per channel. It sits between the last convolution stage and the classifier head. It replaces whole-tensor flattening with a LANES-wide valid/ready stream on both sides. It also adds a runtime average/max mode and frame-length checking.

## Interface
- DATA_WIDTH, 16: signed sample width (two's complement).
- CHANNELS, 160: channel count; must be a multiple of LANES (elaboration error otherwise).
- HEIGHT, 7 / WIDTH, 7: spatial size; HW = HEIGHT*WIDTH.
- LANES, 8: channels per beat; G = CHANNELS/LANES channel groups.
- RSHIFT, 20: reciprocal fraction bits.
- ACC_WIDTH, DATA_WIDTH+$clog2(HW)+1: signed accumulator width.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- mode  in  1  0 = average, 1 = max; sampled on the first accepted beat of a frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- in_data  in  LANES*DATA_WIDTH  lane l at bits [l*DATA_WIDTH +: DATA_WIDTH], channel = group*LANES+l.
- in_last  in  1  producer's end-of-frame marker (checked, not used for sequencing).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*DATA_WIDTH  pooled results, same lane packing.
- out_group  out  $clog2(G)  group index of current out beat.
- out_last  out  1  high on out beat for group G-1.
- frame_err  out  1  sticky framing error flag.

## Operation
- Input order: pixel-major, group-minor: beat k = pixel k/G, group k%G; HW*G beats per frame.
- States: ACCUM (in_ready=1, out_valid=0) and DRAIN (in_ready=0).
- ACCUM: beat counter pix/grp advance on each accepted beat. On pixel 0, acc[grp][l] is loaded with the sample, so no clear cycle is needed. On later pixels, avg mode does acc += sample (sign-extended) and max mode does acc = max(acc, sample), signed.
- mode is latched into mode_q on beat (0,0). Changes to mode mid-frame have no effect.
- Accepting beat (HW-1, G-1) switches to DRAIN.
- DRAIN: G output beats, groups 0..G-1 in order. A beat advances only on out_valid&out_ready. After group G-1 is accepted, the block returns to ACCUM and counters go to 0.
- Average result: sat(((acc*RECIP) + 2^(RSHIFT-1)) >>> RSHIFT), where RECIP = floor(2^RSHIFT/HW + 0.5). The product width is ACC_WIDTH+RSHIFT+1, signed. The shift is arithmetic, so the result is rounded half up. sat clamps to the signed DATA_WIDTH range.
- Max result: acc truncated to DATA_WIDTH, which is exact.
- frame_err is set when either of these happens:
  - in_last=1 on an accepted non-final beat;
  - in_last=0 on the final beat.
  
  Sequencing stays counter-driven. frame_err is cleared only by rst.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_group=0, out_last=0, frame_err=0.
  - State ACCUM, counters 0, mode_q=0.
  - Accumulators are don't-care because they are overwritten on pixel 0.
- Reset mid-frame or mid-drain: the partial frame is discarded and the next accepted beat is treated as (0,0).
- Output registers are loaded with group 0 in the cycle after the final input beat. out_valid rises 1 cycle after that accept.
- Output data is registered. On a handshake the next group is loaded in the same edge, so back-to-back beats run at 1/cycle when out_ready is held high.
- While out_valid=1 and out_ready=0, out_data, out_group and out_last hold stable.
- in_ready returns to 1 in the cycle after the out_last handshake.
- Minimum frame period is HW*G + G + 1 cycles.
- Input accept always happens with in_ready=1. There is no bypass, and there is no overlap of accumulate and drain.

## Structure
- Package gpool_pkg holds:
  - typedef enum {ACCUM, DRAIN} gpool_state_t;
  - typedef enum {POOL_AVG, POOL_MAX} pool_mode_t;
  - function recip(hw, rshift) for the RECIP constant;
  - sat_signed() helper.
- Sub-module gpool_lane, instantiated LANES times. Each instance contains:
  - G×ACC_WIDTH accumulator array;
  - load/accumulate/max update;
  - normalize+saturate read path.
- Top level holds the FSM, counters, frame checking and output register.

## Test plan
Test configuration unless noted: CHANNELS=4, LANES=2, H=W=2 (G=2, RECIP=262144).
- Avg: channel 0 gets 4,8,12,16 over the 4 pixels; all other channels are 0. Expect out beat group 0 to carry lane0=10, and all other outputs=0. out_last is set on the group 1 beat.
- Negative rounding: channel 1 gets -1,-2,-2,-2 (sum -7). Expect -2; channel 3 gets 1,2,2,2 → 2 (1.75 rounds up).
- Max mode: mode=1 at beat 0, then mode=0 mid-frame. Channel 2 gets -5,3,-7,2. Expect 3, because the latched mode is used.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid rises. Expect out_data/out_group stable and in_ready=0 throughout, then 2 back-to-back beats once out_ready goes high.
- Framing: assert in_last on beat 3 of 8. Expect frame_err=1 from the next cycle, normal results after beat 8, and frame_err held until rst.
- Reset mid-frame: rst after beat 5, then a full clean frame. Expect results from the clean frame only, and a default 160/8/7×7 instance to produce its first out_valid exactly 1 cycle after beat 980.
